memory_slave_gen: RTL and testbench

Parametrised memory back-end for the serial bus slave interface. Sits on the parallel side of the slave protocol engine: it accepts write strobes and read requests with an address, stores data in an inferred synchronous RAM of configurable depth, and returns read data with a configurable latency and a one-cycle data-valid pulse. It adds a burst mode with an auto-incrementing address pointer and drop detection for overlapping reads, and it keeps a last-read register for the 7-segment display path.

---
 rtl/memory_slave_gen.sv | 126 ++++++++++++
 tb/tb_memory_slave_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_slave_gen.sv
// Memory back-end for the serial bus slave: inferred RAM, latency-configurable read FSM,
// burst pointer and drop detection. Optional parity via MEM_SLAVE_PARITY_EN.
module memory_slave_gen #(
    parameter int unsigned ADDRESS_WIDTH  = 15,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned MEM_ADDR_WIDTH = 11,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_req,
    input  logic                     burst,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_dv,
    output logic                     rd_busy,
    output logic                     drop_err,
    output logic [DATA_WIDTH-1:0]    disp_data
`ifdef MEM_SLAVE_PARITY_EN
    ,
    output logic                     par_err
`endif
);

    localparam int unsigned DEPTH = 2 ** MEM_ADDR_WIDTH;
`ifdef MEM_SLAVE_PARITY_EN
    localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int unsigned WORD_WIDTH = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {StIdle, StWait, StOut} state_e;

    state_e                    state;
    logic [2:0]                lat_cnt;
    logic [MEM_ADDR_WIDTH-1:0] ptr;
    logic [MEM_ADDR_WIDTH-1:0] raddr;
    logic [MEM_ADDR_WIDTH-1:0] ea;
    logic                      rd_acc;
    logic [WORD_WIDTH-1:0]     wr_word;
    logic [WORD_WIDTH-1:0]     rd_word;
    logic [WORD_WIDTH-1:0]     mem [DEPTH];

    assign ea     = burst ? ptr : addr[MEM_ADDR_WIDTH-1:0];
    assign rd_acc = rd_req && (state == StIdle);

`ifdef MEM_SLAVE_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    // Write-first bypass so a write in the final WAIT cycle is seen by the read.
    assign rd_word = (wr_en && (ea == raddr)) ? wr_word : mem[raddr];

    generate
        if (ADDRESS_WIDTH > MEM_ADDR_WIDTH) begin : g_unused_addr
            logic unused_addr;
            assign unused_addr = ^addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ea] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= StIdle;
            lat_cnt   <= 3'd0;
            ptr       <= '0;
            raddr     <= '0;
            rd_data   <= '0;
            disp_data <= '0;
            rd_dv     <= 1'b0;
            rd_busy   <= 1'b0;
            drop_err  <= 1'b0;
`ifdef MEM_SLAVE_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            rd_dv <= 1'b0;
            // Same-cycle write and read to one ea is a single access.
            if (wr_en || rd_acc) begin
                ptr <= ea + MEM_ADDR_WIDTH'(1);
            end
            if (rd_req && (state != StIdle)) begin
                drop_err <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (rd_req) begin
                        raddr   <= ea;
                        lat_cnt <= 3'(RD_LATENCY);
                        rd_busy <= 1'b1;
                        state   <= StWait;
                    end
                end
                StWait: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        rd_data   <= rd_word[DATA_WIDTH-1:0];
                        disp_data <= rd_word[DATA_WIDTH-1:0];
                        rd_dv     <= 1'b1;
`ifdef MEM_SLAVE_PARITY_EN
                        if (^rd_word) begin
                            par_err <= 1'b1;
                        end
`endif
                        state     <= StOut;
                    end
                end
                StOut: begin
                    rd_busy <= 1'b0;
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_slave_gen.sv
// Table-driven bench for memory_slave_gen: one DUT at RD_LATENCY=1, one at RD_LATENCY=4.
module tb_memory_slave_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic [14:0] addr;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic        rd_req4;
    logic        burst;

    logic [7:0] rd_data1, disp_data1, rd_data4, disp_data4;
    logic       rd_dv1, rd_busy1, drop_err1, rd_dv4, rd_busy4, drop_err4;
`ifdef MEM_SLAVE_PARITY_EN
    logic       par_err1, par_err4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_slave_gen #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rstn(rstn), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req), .burst(burst), .rd_data(rd_data1), .rd_dv(rd_dv1),
        .rd_busy(rd_busy1), .drop_err(drop_err1), .disp_data(disp_data1)
`ifdef MEM_SLAVE_PARITY_EN
        , .par_err(par_err1)
`endif
    );

    memory_slave_gen #(.RD_LATENCY(4)) dut4 (
        .clk(clk), .rstn(rstn), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_req(rd_req4), .burst(burst), .rd_data(rd_data4), .rd_dv(rd_dv4),
        .rd_busy(rd_busy4), .drop_err(drop_err4), .disp_data(disp_data4)
`ifdef MEM_SLAVE_PARITY_EN
        , .par_err(par_err4)
`endif
    );

    typedef struct {
        logic        wr;
        logic [7:0]  wd;
        logic [14:0] a;
        logic        b;
        logic        rd;
        logic        dv;
        logic        busy;
        logic [7:0]  data;
        logic        drop;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [7:0] wd, input logic [14:0] a,
                       input logic b, input logic rd, input logic dv, input logic busy,
                       input logic [7:0] data, input logic drop);
        vec_t v;
        v = '{wr: wr, wd: wd, a: a, b: b, rd: rd, dv: dv, busy: busy, data: data, drop: drop};
        vq.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_data = 8'h00; addr = 15'h0; burst = 1'b0; rd_req = 1'b0; rd_req4 = 1'b0;
    endtask

    initial begin
        int dv_cnt;

        // wr, wd, addr, burst, rd | dv, busy, data, drop
        add(1, 8'hA5, 15'h0010, 0, 0,  0, 0, 8'h00, 0);
        add(0, 8'h00, 15'h0010, 0, 1,  0, 1, 8'h00, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  1, 1, 8'hA5, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'hA5, 0);
        // upper address bits ignored
        add(1, 8'h77, 15'h4012, 0, 0,  0, 0, 8'hA5, 0);
        add(0, 8'h00, 15'h0012, 0, 1,  0, 1, 8'hA5, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  1, 1, 8'h77, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'h77, 0);
        // burst wrap 0x7FF -> 0x000
        add(1, 8'h11, 15'h07FE, 0, 0,  0, 0, 8'h77, 0);
        add(1, 8'h22, 15'h0000, 1, 0,  0, 0, 8'h77, 0);
        add(1, 8'h33, 15'h0000, 1, 0,  0, 0, 8'h77, 0);
        add(0, 8'h00, 15'h07FF, 0, 1,  0, 1, 8'h77, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  1, 1, 8'h22, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'h22, 0);
        add(0, 8'h00, 15'h0000, 0, 1,  0, 1, 8'h22, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  1, 1, 8'h33, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'h33, 0);
        add(0, 8'h00, 15'h07FE, 0, 1,  0, 1, 8'h33, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  1, 1, 8'h11, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'h11, 0);
        // same-cycle write+read at 0x003, then burst read must hit 0x004
        add(1, 8'h99, 15'h0004, 0, 0,  0, 0, 8'h11, 0);
        add(1, 8'h5C, 15'h0003, 0, 1,  0, 1, 8'h11, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  1, 1, 8'h5C, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'h5C, 0);
        add(0, 8'h00, 15'h0000, 1, 1,  0, 1, 8'h5C, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  1, 1, 8'h99, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'h99, 0);
        // write to raddr while the read is in flight
        add(0, 8'h00, 15'h0010, 0, 1,  0, 1, 8'h99, 0);
        add(1, 8'h6E, 15'h0010, 0, 0,  1, 1, 8'h6E, 0);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'h6E, 0);
        // request while busy is dropped
        add(0, 8'h00, 15'h0010, 0, 1,  0, 1, 8'h6E, 0);
        add(0, 8'h00, 15'h0012, 0, 1,  1, 1, 8'h6E, 1);
        add(0, 8'h00, 15'h0000, 0, 0,  0, 0, 8'h6E, 1);

        idle_inputs();
        rstn = 1'b0;
        step();
        step();
        check("reset rd_data", rd_data1, 8'h00);
        check("reset rd_dv", rd_dv1, 1'b0);
        check("reset rd_busy", rd_busy1, 1'b0);
        check("reset drop_err", drop_err1, 1'b0);
        check("reset disp_data", disp_data1, 8'h00);
        check("reset4 rd_busy", rd_busy4, 1'b0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < vq.size(); i++) begin
            wr_en = vq[i].wr; wr_data = vq[i].wd; addr = vq[i].a;
            burst = vq[i].b;  rd_req = vq[i].rd;
            step();
            check($sformatf("v%0d rd_dv", i), rd_dv1, vq[i].dv);
            check($sformatf("v%0d rd_busy", i), rd_busy1, vq[i].busy);
            check($sformatf("v%0d rd_data", i), rd_data1, vq[i].data);
            check($sformatf("v%0d disp_data", i), disp_data1, vq[i].data);
            check($sformatf("v%0d drop_err", i), drop_err1, vq[i].drop);
        end
        idle_inputs();

        // RD_LATENCY=4: busy T+1..T+5, dv only at T+5, second request at T+2 dropped
        addr = 15'h0010;
        dv_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            rd_req4 = (c == 0 || c == 2);
            step();
            if (rd_dv4) dv_cnt++;
            check($sformatf("lat4 c%0d rd_busy", c + 1), rd_busy4, (c + 1 <= 5));
            check($sformatf("lat4 c%0d rd_dv", c + 1), rd_dv4, (c + 1 == 5));
        end
        rd_req4 = 1'b0;
        check("lat4 dv count", dv_cnt, 1);
        check("lat4 drop_err", drop_err4, 1'b1);
        check("lat4 rd_data", rd_data4, 8'h6E);
        check("lat4 disp_data", disp_data4, 8'h6E);

        // Reset mid-read
        addr = 15'h0012; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("midrst busy before", rd_busy1, 1'b1);
        rstn = 1'b0;
        #1;
        check("midrst rd_busy", rd_busy1, 1'b0);
        check("midrst rd_data", rd_data1, 8'h00);
        check("midrst drop_err", drop_err1, 1'b0);
        check("midrst disp_data", disp_data1, 8'h00);
        step();
        check("midrst rd_dv low", rd_dv1, 1'b0);
        rstn = 1'b1;
        dv_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (rd_dv1) dv_cnt++;
        end
        check("midrst no dv", dv_cnt, 0);
        check("midrst drop4 cleared", drop_err4, 1'b0);
        addr = 15'h0012; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        check("post-rst rd_dv", rd_dv1, 1'b1);
        check("post-rst rd_data", rd_data1, 8'h77);
        step();

`ifdef MEM_SLAVE_PARITY_EN
        addr = 15'h0020; wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_en = 1'b0; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        check("par clean rd_data", rd_data1, 8'h3C);
        check("par clean par_err", par_err1, 1'b0);
        step();
        dut1.mem[32] = dut1.mem[32] ^ 9'h001;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        check("par flip rd_data", rd_data1, 8'h3D);
        check("par flip par_err", par_err1, 1'b1);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
